div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle divide sequencer for the EX stage. It accepts a 32-bit signed or unsigned DIV/DIVU request from EX and runs a radix-2 restoring divider, one quotient bit per cycle. While the operation is in flight it raises a stall request to the pipeline controller, then presents {remainder, quotient} for the HI/LO write.

## Interface
- N_DATA, 32: operand width (`N_REG`); result width is 2*N_DATA.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low (`RST_ENABLE` = 0).
- i_start  in  1  EX requests a division; held high until o_ready is seen.
- i_annul  in  1  cancel any in-flight or completed operation (pipeline flush).
- i_signed  in  1  1 = DIV, 0 = DIVU; sampled with i_start in IDLE.
- i_dividend  in  N_DATA  rs operand; sampled in IDLE.
- i_divisor  in  N_DATA  rt operand; sampled in IDLE.
- o_result  out  2*N_DATA  {remainder[63:32] → HI, quotient[31:0] → LO}.
- o_ready  out  1  o_result valid.
- o_streq  out  1  stall request to the pipeline controller.

## Operation
- States: IDLE, DIVZERO, BUSY, DONE.
- IDLE + i_start & !i_annul:
  - If divisor == 0, go to DIVZERO.
  - Otherwise go to BUSY: latch the operands (absolute values when i_signed), latch the sign flags, clear step counter cnt.
- DIVZERO: always goes to DONE next cycle with o_result = 0.
- BUSY, each cycle:
  - partial = {rem, next dividend MSB}.
  - If partial ≥ divisor: rem = partial − divisor and q bit = 1.
  - Else rem = partial and q bit = 0.
  - cnt increments 0..31. After step 31, go to DONE.
- Sign correction on the BUSY→DONE transition:
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) yields quotient 0x80000000, remainder 0 (two's-complement wrap, no trap).
- DONE: o_ready = 1 and o_result is held. Stay in DONE while i_start = 1; go to IDLE when i_start = 0.
- i_annul in any non-IDLE state: go to IDLE next cycle. o_ready = 0 and o_result = 0 from that cycle on.
- i_annul in IDLE: i_start is ignored.
- Operand changes after acceptance are ignored.
- A back-to-back divide needs i_start low for at least one cycle.
- o_streq = i_start & !i_annul & (state != DONE). This is combinational, so the stall applies in the same cycle as the request.
- Arithmetic: partial remainder is 33 bits so the compare never overflows. Quotient and remainder are exactly 32 bits.

## Timing
- Reset (async, immediate, from any state): state = IDLE, cnt = 0, o_result = 0, o_ready = 0. o_streq follows its equation, so it is 0 unless i_start is high.
- Nonzero divisor, i_start accepted in cycle N:
  - BUSY occupies cycles N+1..N+32.
  - o_ready is high from cycle N+33.
  - o_streq is high in cycles N..N+32.
- Zero divisor: DIVZERO in cycle N+1, o_ready from cycle N+2.
- o_result is registered and changes only on the entry to DONE and on annul/reset.
- Annul sampled high in cycle M: o_streq drops in cycle M; state = IDLE from M+1.
- i_start and i_annul high together in IDLE: no acceptance, o_streq = 0.

## Structure
- Shared package:
  - typedef div_state_t {DIV_IDLE, DIV_ZERO, DIV_BUSY, DIV_DONE}.
  - DIV_STEPS = 32.
  - `EXE_DIV_OP` / `EXE_DIVU_OP` codes, added next to the existing ALU op defines.
- One natural sub-module: div_step, the combinational single restoring step (33-bit compare/subtract → next rem, q bit).
- Top level holds the FSM, counter, operand/sign registers and sign correction.

## Test plan
- Unsigned 100 / 7, i_signed = 0 → o_ready exactly 33 cycles after acceptance; o_result = {0x00000002, 0x0000000E}; o_streq high for 33 cycles, then low.
- Signed −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- 5 / 0 → o_ready in cycle N+2 with o_result = 0. Signed 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}.
- i_annul pulsed at N+10 → o_streq drops that cycle and o_ready never rises. A fresh start of 0xFFFFFFFF / 0x10 (unsigned) right after completes as {0xF, 0x0FFFFFFF}.
- i_start held 5 cycles after o_ready → result and o_ready stable throughout. Drop i_start → IDLE the next cycle, o_ready = 0.
- i_rst_n asserted mid-BUSY (cnt = 15), asynchronously between clock edges → o_ready and o_result are 0 immediately. After release, a new 100 / 7 gives the correct result.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared types and constants for the EX-stage multi-cycle divider.
package div_seq_pkg;

    localparam int N_REG     = 32;
    localparam int DIV_STEPS = 32;

    // ALU op codes, alongside the existing EX op encodings
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_ZERO,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/div_seq_if.sv
// EX <-> divider request/response bundle.
interface div_seq_if #(parameter int N_DATA = 32);

    logic                  i_start;
    logic                  i_annul;
    logic                  i_signed;
    logic [N_DATA-1:0]     i_dividend;
    logic [N_DATA-1:0]     i_divisor;
    logic [2*N_DATA-1:0]   o_result;
    logic                  o_ready;
    logic                  o_streq;

    modport master (
        output i_start, i_annul, i_signed, i_dividend, i_divisor,
        input  o_result, o_ready, o_streq
    );

    modport slave (
        input  i_start, i_annul, i_signed, i_dividend, i_divisor,
        output o_result, o_ready, o_streq
    );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int N_DATA = 32
) (
    input  logic [N_DATA-1:0] rem,
    input  logic              msb,
    input  logic [N_DATA-1:0] divisor,
    output logic [N_DATA-1:0] rem_next,
    output logic              q_bit
);

    logic [N_DATA:0] partial;
    logic [N_DATA:0] diff;

    assign partial = {rem, msb};
    assign diff    = partial - {1'b0, divisor};

    // rem < divisor keeps partial < 2*divisor, so the borrow bit alone decides partial >= divisor
    assign q_bit    = ~diff[N_DATA];
    assign rem_next = q_bit ? diff[N_DATA-1:0] : partial[N_DATA-1:0];

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned divide sequencer: FSM, operand registers and sign fix-up.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int N_DATA = N_REG
) (
    input logic      i_clk,
    input logic      i_rst_n,
    div_seq_if.slave bus
);

    localparam int               CNT_W    = $clog2(DIV_STEPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_STEPS - 1);

    div_state_t              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [N_DATA-1:0]       rem_q, dvd_q, dvs_q, rem_nxt;
    logic                    q_bit, neg_quo_q, neg_rem_q;
    logic                    accept, last_step, annul_hit;
    logic                    dvd_neg, dvs_neg;
    logic [2*N_DATA-1:0]     result_q;
    logic signed [N_DATA-1:0] dividend_s, divisor_s;

    function automatic logic [N_DATA-1:0] neg_if(input logic neg, input logic [N_DATA-1:0] x);
        return neg ? (~x + 1'b1) : x;
    endfunction

    assign dividend_s = bus.i_dividend;
    assign divisor_s  = bus.i_divisor;
    assign dvd_neg    = bus.i_signed && (dividend_s < 0);
    assign dvs_neg    = bus.i_signed && (divisor_s < 0);

    assign accept    = (state_q == DIV_IDLE) && bus.i_start && !bus.i_annul && (bus.i_divisor != '0);
    assign last_step = (state_q == DIV_BUSY) && (cnt_q == CNT_LAST);
    assign annul_hit = (state_q != DIV_IDLE) && bus.i_annul;

    div_step #(.N_DATA(N_DATA)) u_step (
        .rem      (rem_q),
        .msb      (dvd_q[N_DATA-1]),
        .divisor  (dvs_q),
        .rem_next (rem_nxt),
        .q_bit    (q_bit)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (bus.i_start && !bus.i_annul)
                          state_d = (bus.i_divisor == '0) ? DIV_ZERO : DIV_BUSY;
            DIV_ZERO: state_d = DIV_DONE;
            DIV_BUSY: if (cnt_q == CNT_LAST) state_d = DIV_DONE;
            DIV_DONE: if (!bus.i_start) state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        if (annul_hit) state_d = DIV_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept)
                cnt_q <= '0;
            else if (state_q == DIV_BUSY)
                cnt_q <= cnt_q + 1'b1;
            if (annul_hit || state_q == DIV_ZERO)
                result_q <= '0;
            else if (last_step)
                result_q <= {neg_if(neg_rem_q, rem_nxt),
                             neg_if(neg_quo_q, {dvd_q[N_DATA-2:0], q_bit})};
        end
    end

    // Dividend register doubles as the quotient shift register: one bit out, one bit in per step
    always_ff @(posedge i_clk) begin
        if (accept) begin
            dvd_q     <= neg_if(dvd_neg, bus.i_dividend);
            dvs_q     <= neg_if(dvs_neg, bus.i_divisor);
            rem_q     <= '0;
            neg_quo_q <= dvd_neg ^ dvs_neg;
            neg_rem_q <= dvd_neg;
        end else if (state_q == DIV_BUSY) begin
            rem_q <= rem_nxt;
            dvd_q <= {dvd_q[N_DATA-2:0], q_bit};
        end
    end

    assign bus.o_result = result_q;
    assign bus.o_ready  = (state_q == DIV_DONE);
    assign bus.o_streq  = bus.i_start && !bus.i_annul && (state_q != DIV_DONE);

endmodule

// File: tb/tb_div_seq.sv
// Directed plus randomized bench for div_seq against an arithmetic reference model.
module tb_div_seq;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    div_seq_if #(.N_DATA(32)) bus ();

    div_seq #(.N_DATA(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one divide from an IDLE cycle, measure latency and stall length, optionally hold i_start.
    task automatic do_div(input string tag, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int          cyc;
        int          streq_n;
        int          exp_lat;
        logic [63:0] exp;
        exp     = model(sgn, a, b);
        exp_lat = (b == 32'd0) ? 2 : 33;
        bus.i_signed   = sgn;
        bus.i_dividend = a;
        bus.i_divisor  = b;
        bus.i_annul    = 1'b0;
        bus.i_start    = 1'b1;
        #1;
        check({tag, " streq_accept"}, 64'(bus.o_streq), 64'd1);
        cyc     = 0;
        streq_n = 0;
        while (cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            bus.i_dividend = $urandom;
            bus.i_divisor  = $urandom;
            bus.i_signed   = 1'($urandom);
            if (bus.o_ready) break;
            streq_n += int'(bus.o_streq);
        end
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " streq_cycles"}, 64'(streq_n), 64'(exp_lat - 1));
        check({tag, " streq_done"}, 64'(bus.o_streq), 64'd0);
        check({tag, " result"}, bus.o_result, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, " hold_ready"}, 64'(bus.o_ready), 64'd1);
            check({tag, " hold_result"}, bus.o_result, exp);
        end
        bus.i_start = 1'b0;
        @(posedge clk); #1;
        check({tag, " idle_ready"}, 64'(bus.o_ready), 64'd0);
    endtask

    initial begin
        int          ready_seen;
        bit          sgn;
        logic [31:0] a, b;

        rst_n          = 1'b0;
        bus.i_start    = 1'b0;
        bus.i_annul    = 1'b0;
        bus.i_signed   = 1'b0;
        bus.i_dividend = '0;
        bus.i_divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 64'(bus.o_ready), 64'd0);
        check("reset result", bus.o_result, 64'd0);
        check("reset streq", 64'(bus.o_streq), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_div("u100_7", 1'b0, 32'd100, 32'd7, 0);
        check("u100_7 const", {32'h2, 32'hE}, model(1'b0, 32'd100, 32'd7));
        do_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        do_div("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        do_div("div0", 1'b0, 32'd5, 32'd0, 0);
        do_div("min_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // start together with annul in IDLE must not be accepted
        bus.i_start    = 1'b1;
        bus.i_annul    = 1'b1;
        bus.i_dividend = 32'd50;
        bus.i_divisor  = 32'd5;
        #1;
        check("idle_annul streq", 64'(bus.o_streq), 64'd0);
        @(posedge clk); #1;
        do_div("after_idle_annul", 1'b0, 32'd50, 32'd5, 0);

        // annul in the middle of BUSY
        bus.i_signed   = 1'b0;
        bus.i_dividend = 32'd1000;
        bus.i_divisor  = 32'd3;
        bus.i_start    = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        bus.i_annul = 1'b1;
        #1;
        check("annul streq", 64'(bus.o_streq), 64'd0);
        @(posedge clk); #1;
        bus.i_annul = 1'b0;
        bus.i_start = 1'b0;
        check("annul result", bus.o_result, 64'd0);
        ready_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            ready_seen += int'(bus.o_ready);
        end
        check("annul no_ready", 64'(ready_seen), 64'd0);
        do_div("fffffff_10", 1'b0, 32'hFFFF_FFFF, 32'h10, 0);

        do_div("hold", 1'b1, 32'hFFFF_FF00, 32'd9, 5);

        // asynchronous reset while cnt = 15
        bus.i_signed   = 1'b0;
        bus.i_dividend = 32'd12345;
        bus.i_divisor  = 32'd11;
        bus.i_start    = 1'b1;
        repeat (16) begin
            @(posedge clk); #1;
        end
        bus.i_start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst ready", 64'(bus.o_ready), 64'd0);
        check("async_rst result", bus.o_result, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_div("post_rst_100_7", 1'b0, 32'd100, 32'd7, 0);

        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 255);
                2:       b = $urandom | 32'h8000_0000;
                default: b = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 15));
            endcase
            do_div($sformatf("rand%0d", i), sgn, a, b, i % 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
